// File: rtl/dmem_if.sv
// Core-to-data-memory bus: store strobe, address, lane-placed data and mask,
// plus the load data and program/timer status returned to the core.
interface dmem_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  byteEnable;
  logic [31:0] RD_data;
  logic        done;
  logic [31:0] exit_code;
  logic        timer_irq;

  modport master (
    output MemWriteM, ALUResultM, WriteDataM, byteEnable,
    input  RD_data, done, exit_code, timer_irq
  );

  modport slave (
    input  MemWriteM, ALUResultM, WriteDataM, byteEnable,
    output RD_data, done, exit_code, timer_irq
  );
endinterface

// File: rtl/dmem.sv
// Data memory: aliased word RAM with combinational read, plus an MMIO window
// (TOHOST/STATUS and, when DMEM_TIMER_EN is defined, a 64-bit mtime/mtimecmp timer).
module dmem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input logic   clk,
  input logic   clr,
  dmem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [4:0] OFF_TOHOST = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
`ifdef DMEM_TIMER_EN
  localparam logic [4:0] OFF_MTIME_LO    = 5'h08;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h0C;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h10;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h14;
`endif

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic             is_mmio_s;
  logic [4:0]       off_s;
  logic             mmio_wr_s;
  logic             tohost_wr_s;
  logic             done_r;
  logic [31:0]      exit_code_r;
  logic [31:0]      rd_s;

  assign idx_s       = bus.ALUResultM[IDX_W+1:2];
  assign is_mmio_s   = bus.ALUResultM[31];
  // Only the low five offset bits are decoded, so low-bit subtraction suffices.
  assign off_s       = bus.ALUResultM[4:0] - MMIO_BASE[4:0];
  assign mmio_wr_s   = bus.MemWriteM & is_mmio_s & (bus.byteEnable == 4'b1111);
  assign tohost_wr_s = mmio_wr_s & (off_s == OFF_TOHOST);

  // Lane-masked RAM store; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.MemWriteM && !is_mmio_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteEnable[i]) begin
          mem_r[idx_s][8*i +: 8] <= bus.WriteDataM[8*i +: 8];
        end
      end
    end
  end

  // First TOHOST write latches the exit code; later ones are ignored until reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done_r      <= 1'b0;
      exit_code_r <= 32'h0000_0000;
    end else if (tohost_wr_s && !done_r) begin
      done_r      <= 1'b1;
      exit_code_r <= bus.WriteDataM;
    end
  end

`ifdef DMEM_TIMER_EN
  logic [63:0] mtime_r;
  logic [63:0] mtime_nxt_s;
  logic [63:0] mtimecmp_r;
  logic [63:0] mtimecmp_nxt_s;
  logic        timer_irq_r;

  // Timer next state: a write to either mtime half replaces that cycle's increment.
  always_comb begin
    mtime_nxt_s    = mtime_r + 64'd1;
    mtimecmp_nxt_s = mtimecmp_r;
    if (mmio_wr_s) begin
      case (off_s)
        OFF_MTIME_LO:    mtime_nxt_s    = {mtime_r[63:32], bus.WriteDataM};
        OFF_MTIME_HI:    mtime_nxt_s    = {bus.WriteDataM, mtime_r[31:0]};
        OFF_MTIMECMP_LO: mtimecmp_nxt_s = {mtimecmp_r[63:32], bus.WriteDataM};
        OFF_MTIMECMP_HI: mtimecmp_nxt_s = {bus.WriteDataM, mtimecmp_r[31:0]};
        default:         mtimecmp_nxt_s = mtimecmp_r;
      endcase
    end else begin
      mtime_nxt_s = mtime_r + 64'd1;
    end
  end

  // Timer registers; the interrupt compares the values being loaded this edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mtime_r     <= 64'h0;
      mtimecmp_r  <= {64{1'b1}};
      timer_irq_r <= 1'b0;
    end else begin
      mtime_r     <= mtime_nxt_s;
      mtimecmp_r  <= mtimecmp_nxt_s;
      timer_irq_r <= (mtime_nxt_s >= mtimecmp_nxt_s);
    end
  end

  assign bus.timer_irq = timer_irq_r;
`else
  assign bus.timer_irq = 1'b0;
`endif

  // Load data: raw RAM word, or MMIO register with unmapped offsets reading zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (!is_mmio_s) begin
      rd_s = mem_r[idx_s];
    end else begin
      case (off_s)
        OFF_TOHOST:      rd_s = exit_code_r;
        OFF_STATUS:      rd_s = {31'h0, done_r};
`ifdef DMEM_TIMER_EN
        OFF_MTIME_LO:    rd_s = mtime_r[31:0];
        OFF_MTIME_HI:    rd_s = mtime_r[63:32];
        OFF_MTIMECMP_LO: rd_s = mtimecmp_r[31:0];
        OFF_MTIMECMP_HI: rd_s = mtimecmp_r[63:32];
`endif
        default:         rd_s = 32'h0000_0000;
      endcase
    end
  end

  assign bus.RD_data   = rd_s;
  assign bus.done      = done_r;
  assign bus.exit_code = exit_code_r;
endmodule

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 DEPTH_WORDS, 1024, RAM size in 32-bit words; SHALL be a power of two >= 4.
REQ-002 MMIO_BASE, 32'h8000_0000, base of the MMIO window; address bit 31 set selects MMIO.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 MemWriteM  input  1  store strobe from the core M stage.
REQ-006 ALUResultM  input  32  byte address for the load or store.
REQ-007 WriteDataM  input  32  store data, already placed in its byte lanes.
REQ-008 byteEnable  input  4  store lane mask; bit i covers bits [8i+7:8i].
REQ-009 RD_data  output  32  load data to the core, full aligned word.
REQ-010 done  output  1  program-complete flag.
REQ-011 exit_code  output  32  value captured by the first TOHOST write.
REQ-012 timer_irq  output  1  level timer interrupt.

Function
REQ-013 RAM region SHALL be selected when ALUResultM[31]==0; word index = ALUResultM[log2(DEPTH_WORDS)+1:2]; higher address bits ignored, so the RAM aliases.
REQ-014 RAM read SHALL be combinational: RD_data = mem[index] in the same cycle, zero wait states, no lane shifting.
REQ-015 RAM write SHALL occur on the clk edge when MemWriteM=1; only the lanes with byteEnable[i]=1 update; byteEnable=0000 writes nothing.
REQ-016 A load from a word being stored in the same cycle SHALL return the old contents.
REQ-017 MMIO offsets (ALUResultM - MMIO_BASE, bits [4:0]): 0x00 TOHOST, 0x04 STATUS (read-only, bit0=done), 0x08 MTIME_LO, 0x0C MTIME_HI, 0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI.
REQ-018 Reads of unmapped MMIO offsets SHALL return 0; writes to them SHALL be ignored.
REQ-019 MMIO writes SHALL take effect only when byteEnable==1111; partial-width MMIO writes are ignored.
REQ-020 Writing TOHOST while done=0 SHALL set done=1 and exit_code=WriteDataM on the next edge.
REQ-021 While done=1, further TOHOST writes SHALL be ignored; done and exit_code stay unchanged until reset.
REQ-022 The 64-bit mtime SHALL increment by 1 every cycle and wrap from 2^64-1 to 0.
REQ-023 A write to MTIME_LO or MTIME_HI SHALL load that half and suppress the increment for that cycle; the other half is held.
REQ-024 A load from MTIME_LO or MTIME_HI SHALL return the pre-increment register value for that cycle.
REQ-025 timer_irq SHALL be registered: timer_irq = (mtime >= mtimecmp), unsigned, evaluated on each edge from the post-update values.

Reset
REQ-026 While clr=1, these SHALL be forced immediately, independent of clk: done=0, exit_code=0, mtime=0, mtimecmp=all ones, timer_irq=0.
REQ-027 RAM contents SHALL NOT be reset; RD_data for the RAM region reflects the RAM contents during reset.
REQ-028 An asserted clr SHALL override any store issued in the same cycle to MMIO registers.

Configuration
REQ-029 Macro DMEM_TIMER_EN: when defined, mtime, mtimecmp and timer_irq SHALL be implemented per REQ-022..025.
REQ-030 When DMEM_TIMER_EN is undefined, offsets 0x08..0x14 SHALL read 0 and ignore writes, timer_irq SHALL be tied to 0, and no timer registers SHALL be inferred.

Verification
REQ-031 Store 0xDEADBEEF with byteEnable=1111 to 0x10, then store 0x000000AA with byteEnable=0001 to 0x10 -> a load from 0x10 returns 0xDEADBEAA.
REQ-032 Store to address 0x10 + 4*DEPTH_WORDS -> a load from 0x10 returns the same data (aliasing).
REQ-033 Write 0x1 to TOHOST, then write 0x7 -> done=1 and exit_code=0x1; STATUS reads 0x1.
REQ-034 With DMEM_TIMER_EN defined: set MTIMECMP_HI=0, MTIMECMP_LO=20, clear MTIME_LO and MTIME_HI -> timer_irq rises exactly when mtime reaches 20.
REQ-035 Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0xFFFFFFFF -> after one cycle both halves read 0 (wrap).
REQ-036 Assert clr asynchronously between edges while done=1 and the timer is running -> done, exit_code, mtime and timer_irq are 0 immediately, while previously written RAM data is still readable.
